// File: rtl/mm_job_scheduler.sv
// Round-robin job scheduler for a matrix-multiply unit with a skid-buffered
// result drain. Define MM_SCHED_TIMEOUT_EN to add the WAIT_DONE watchdog (err).
module mm_job_scheduler #(
   parameter int N       = 16,
   parameter int DW      = 32,
   parameter int AW      = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   output logic [1:0]    grant,
   output logic          busy,
   output logic          cu_start,
   input  logic          cu_done,
   output logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_q,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
`ifdef MM_SCHED_TIMEOUT_EN
   output logic          err,
`endif
   output logic          job_done
);

   localparam logic [AW-1:0] LAST = AW'(N * N - 1);

   if (AW < $clog2(N * N) || TIMEOUT < 1) begin : g_param_check
      $error("mm_job_scheduler: bad AW or TIMEOUT");
   end

   typedef enum logic [2:0] {IDLE, START, WAIT_DONE, DRAIN, FINISH} state_t;

   state_t          state, nxt;
   logic [1:0]      win;
   logic            prio;
   logic            tmo;
   logic            fire, issue;
   logic [1:0]      use_cnt;
   logic            rd_pend, all_rd;
   logic            skid_v;
   logic [DW-1:0]   skid_d;
   logic [AW-1:0]   out_cnt;

   assign busy     = (state != IDLE);
   assign cu_start = (state == START);
   assign job_done = (state == FINISH);
   assign out_last = out_valid && (out_cnt == LAST);
   assign fire     = out_valid && out_ready;

   // Output register + skid entry hold two elements; count the read in flight.
   assign use_cnt = 2'(out_valid) + 2'(skid_v) + 2'(rd_pend) - 2'(fire);
   assign issue   = (state == DRAIN) && !all_rd && (use_cnt < 2'd2);

`ifdef MM_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_cnt;

   assign tmo = !cu_done && (wd_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || state != WAIT_DONE) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else if (state == WAIT_DONE && tmo) err <= 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end

   always_comb begin
      nxt = state;
      win = 2'b00;
      unique case (state)
         IDLE: begin
            if (|req) begin
               nxt = START;
               if (req == 2'b11) win = prio ? 2'b10 : 2'b01;
               else win = req;
            end
         end
         START: nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (cu_done) nxt = DRAIN;
            else if (tmo) nxt = IDLE;
         end
         DRAIN: if (fire && out_last) nxt = FINISH;
         FINISH: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant     <= 2'b00;
         prio      <= 1'b0;
         c_addr    <= '0;
         all_rd    <= 1'b0;
         rd_pend   <= 1'b0;
         skid_v    <= 1'b0;
         skid_d    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
      end else begin
         if (state == IDLE && nxt == START) begin
            grant <= win;
            prio  <= win[0];
         end else if (nxt == IDLE) begin
            grant <= 2'b00;
         end

         if (issue) begin
            c_addr <= c_addr + AW'(1);
            all_rd <= (c_addr == LAST);
         end
         rd_pend <= issue;

         // Oldest data first: skid entry, then the word returning from BRAM.
         if (!out_valid || fire) begin
            if (skid_v) begin
               out_data  <= skid_d;
               out_valid <= 1'b1;
               skid_v    <= rd_pend;
               skid_d    <= c_q;
            end else begin
               out_valid <= rd_pend;
               if (rd_pend) out_data <= c_q;
            end
         end else if (rd_pend) begin
            skid_v <= 1'b1;
            skid_d <= c_q;
         end

         if (fire) out_cnt <= out_cnt + AW'(1);

         if (state == FINISH) begin
            c_addr  <= '0;
            all_rd  <= 1'b0;
            out_cnt <= '0;
         end
      end
   end

endmodule
